// File: rtl/octal_step_counter.sv
// octal_step_counter: 3-bit up/down step counter driven by two debounced
// push-buttons and an optional free-running auto-increment (RUN/PRESCALE).
// Build option: define OCTAL_STEP_WRAP_EN for modulo-8 wrap-around; when it is
// left undefined the count saturates at 0 and 7.
module octal_step_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PRESCALE        = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UP_BTN,
  input  logic       DN_BTN,
  input  logic       RUN,
  output logic [2:0] ABC,
  output logic       STEP
);

  localparam int unsigned DBW = 10;
  localparam int unsigned PSW = 16;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

  // Bit 0 carries the UP button, bit 1 the DN button.
  logic [1:0]          w_btn;
  logic [1:0]          r_meta;
  logic [1:0]          r_sync;
  logic [1:0]          r_level;
  logic [1:0]          r_evt;
  logic [1:0][DBW-1:0] r_db_cnt;
  logic [PSW-1:0]      r_ps_cnt;
  logic                w_tick;
  logic                w_inc;
  logic                w_dec;
  logic [2:0]          w_next;

  assign w_btn = {DN_BTN, UP_BTN};

  // Two-flop synchronizer for the raw, asynchronous button inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_btn;
      r_sync <= r_meta;
    end
  end

  // Debounce: flip the level after DEBOUNCE_CYCLES consecutive differing
  // samples; a rising flip emits a one-cycle press event in the next cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_level  <= '0;
      r_evt    <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync[i] != r_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_level[i]  <= r_sync[i];
            r_evt[i]    <= r_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_tick = RUN && (r_ps_cnt == PS_LAST);

  // Auto-run prescaler; dropping RUN restarts the period from zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ps_cnt <= '0;
    end else if (!RUN || w_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + PSW'(1);
    end
  end

  // Arbitrate: both buttons cancel each other, a button beats the tick.
  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    unique case (r_evt)
      2'b01:   w_inc = 1'b1;
      2'b10:   w_dec = 1'b1;
      2'b00:   w_inc = w_tick;
      default: ;
    endcase
  end

  // Next count value, wrapping or saturating at the ends.
  always_comb begin
    w_next = ABC;
`ifdef OCTAL_STEP_WRAP_EN
    if (w_inc) begin
      w_next = ABC + 3'd1;
    end else if (w_dec) begin
      w_next = ABC - 3'd1;
    end
`else
    if (w_inc && (ABC != 3'd7)) begin
      w_next = ABC + 3'd1;
    end else if (w_dec && (ABC != 3'd0)) begin
      w_next = ABC - 3'd1;
    end
`endif
  end

  // Output register; STEP marks the first cycle of a new value only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ABC  <= 3'd0;
      STEP <= 1'b0;
    end else begin
      ABC  <= w_next;
      STEP <= (w_next != ABC);
    end
  end

endmodule

// File: doc/octal_step_counter.md
OCTAL_STEP_COUNTER -- requirements
Module: octal_step_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized samples required to accept a button level change; legal range 2..1023.
REQ-002 Parameter PRESCALE, default 8: clock cycles per auto-run increment; legal range 2..65535.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 UP_BTN  input  1  raw, asynchronous, bouncing increment button, active high.
REQ-006 DN_BTN  input  1  raw, asynchronous, bouncing decrement button, active high.
REQ-007 RUN  input  1  synchronous auto-run enable; when high, ABC advances every PRESCALE cycles.
REQ-008 ABC  output  3  registered octal value 0..7; feeds the 7-segment decoder select directly.
REQ-009 STEP  output  1  registered one-cycle strobe, high in the first cycle ABC holds a new value.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Debounce: per button, a counter SHALL count consecutive cycles in which the synchronized value differs from the debounced level; any equal sample clears it; the debounced level SHALL flip on the edge of the DEBOUNCE_CYCLES-th consecutive differing sample.
REQ-012 A press event SHALL be a 0->1 transition of the debounced level only; releases generate no event.
REQ-013 Latency: a raw press held clean from edge 1 SHALL change ABC on rising edge DEBOUNCE_CYCLES+3.
REQ-014 Prescaler: while RUN=1, a counter SHALL cycle 0..PRESCALE-1 and issue a tick on the edge where it equals PRESCALE-1; RUN=0 SHALL clear it to 0 on the next edge.
REQ-015 Update priority per cycle: UP and DN events together -> no change and tick discarded; a single button event -> apply it and discard any coincident tick; tick alone -> increment.
REQ-016 Arithmetic SHALL be 3-bit modulo 8 when wrap is enabled (7+1=0, 0-1=7); see REQ-021.
REQ-017 STEP SHALL assert for exactly one cycle if and only if ABC changed on the preceding edge; a blocked update (saturation or cancelled) SHALL NOT assert STEP.
REQ-018 ABC and STEP SHALL be driven directly from flops with no combinational path from any input.

Reset
REQ-019 RST_N low SHALL immediately force ABC=0, STEP=0, synchronizer flops=0, debounced levels=0, debounce and prescale counters=0, regardless of CLK.
REQ-020 A button held through reset deassertion SHALL register as exactly one press after the REQ-013 latency; reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-021 Macro OCTAL_STEP_WRAP_EN: defined -> wrap-around per REQ-016; undefined -> saturate, increment at 7 and decrement at 0 leave ABC unchanged with STEP=0 and the event consumed.

Verification
REQ-022 DEBOUNCE_CYCLES=4, clean UP press from ABC=0 -> ABC=1 on edge 7, STEP high for one cycle, no further change while held.
REQ-023 UP toggling every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one increment after stable.
REQ-024 PRESCALE=8, RUN=1 after reset -> ABC steps 0,1,2... every 8 cycles; with wrap 7->0; without wrap holds at 7, STEP silent.
REQ-025 UP and DN debounced edges in same cycle at ABC=3 -> ABC stays 3, STEP=0; DN alone at ABC=0 -> 7 with wrap, 0 without.
REQ-026 RST_N pulsed low mid-debounce and with ABC=5 -> ABC=0, STEP=0 immediately; button still held -> single press counted after release.
